mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single data-memory port (a_mem/sd_mem/ld_mem/mem_write_flag/mem_read_flag). It lets the core's memory unit (port 0) and a second requester share one BRAM port; port 1 is a UART program/data loader or debug DMA. Both requesters use the core's order/accepted/done handshake. The arbiter serialises their transactions and hides the fixed BRAM read latency.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer sharing one BRAM data port with a fixed read latency.
// Optional feature macro MEM_ARB_RR_EN: round-robin tie-break (default: port 0 fixed priority).
module mem_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              r0_order,
    input  logic              r0_write,
    input  logic [3:0]        r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_accepted,
    output logic              r0_done,
    output logic [31:0]       r0_rdata,
    input  logic              r1_order,
    input  logic              r1_write,
    input  logic [3:0]        r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_accepted,
    output logic              r1_done,
    output logic [31:0]       r1_rdata,
    output logic [ADDR_W-1:0] a_mem,
    output logic [31:0]       sd_mem,
    input  logic [31:0]       ld_mem,
    output logic [3:0]        mem_write_flag,
    output logic              mem_read_flag,
    output logic              busy,
    output logic              grant
);

    localparam int               CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q;
    logic              grant_q;
    logic              wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] a_mem_q;
    logic [31:0]       sd_mem_q;
    logic [3:0]        wflag_q;
    logic              rflag_q;
    logic [1:0]        acc_q;
    logic [1:0]        done_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic              any_order;
    logic              win_d;
    logic              sel_wr_d;
    logic [3:0]        sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [31:0]       sel_wdata_d;

    // Winner selection only feeds registers, so no order reaches the memory pins combinationally.
    always_comb begin
        any_order = r0_order | r1_order;
        win_d     = r1_order & ~r0_order;
`ifdef MEM_ARB_RR_EN
        if (r0_order && r1_order) begin
            win_d = ~grant_q;
        end
`endif
        sel_wr_d    = win_d ? r1_write : r0_write;
        sel_we_d    = win_d ? r1_we    : r0_we;
        sel_addr_d  = win_d ? r1_addr  : r0_addr;
        sel_wdata_d = win_d ? r1_wdata : r0_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= 1'b1;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            a_mem_q  <= '0;
            sd_mem_q <= '0;
            wflag_q  <= '0;
            rflag_q  <= 1'b0;
            acc_q    <= '0;
            done_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            acc_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_order) begin
                        state_q  <= ISSUE;
                        grant_q  <= win_d;
                        wr_q     <= sel_wr_d;
                        acc_q    <= win_d ? 2'b10 : 2'b01;
                        a_mem_q  <= sel_addr_d;
                        sd_mem_q <= sel_wdata_d;
                        wflag_q  <= sel_wr_d ? sel_we_d : 4'b0000;
                        rflag_q  <= ~sel_wr_d;
                    end
                end
                ISSUE: begin
                    wflag_q  <= '0;
                    rflag_q  <= 1'b0;
                    sd_mem_q <= '0;
                    if (wr_q) begin
                        state_q <= IDLE;
                        a_mem_q <= '0;
                        done_q  <= grant_q ? 2'b10 : 2'b01;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    // a_mem is held here so the BRAM sees a stable address for the whole latency.
                    if (cnt_q == '0) begin
                        if (grant_q) begin
                            rdata1_q <= ld_mem;
                        end else begin
                            rdata0_q <= ld_mem;
                        end
                        done_q  <= grant_q ? 2'b10 : 2'b01;
                        state_q <= IDLE;
                        a_mem_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_accepted    = acc_q[0];
    assign r1_accepted    = acc_q[1];
    assign r0_done        = done_q[0];
    assign r1_done        = done_q[1];
    assign r0_rdata       = rdata0_q;
    assign r1_rdata       = rdata1_q;
    assign a_mem          = a_mem_q;
    assign sd_mem         = sd_mem_q;
    assign mem_write_flag = wflag_q;
    assign mem_read_flag  = rflag_q;
    assign busy           = (state_q != IDLE);
    assign grant          = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random two-port traffic against a transaction-level model and a BRAM model.
module tb_mem_arbiter;
    localparam int ADDR_W = 17;
    localparam int RL     = 3;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              ord   [2];
    logic              wr    [2];
    logic [3:0]        we    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [31:0]       wdata [2];

    logic r0_accepted, r1_accepted, r0_done, r1_done;
    logic [31:0] r0_rdata, r1_rdata;
    logic [ADDR_W-1:0] a_mem;
    logic [31:0] sd_mem, ld_mem;
    logic [3:0] mem_write_flag;
    logic mem_read_flag, busy, grant;

    logic [1:0]  acc, done;
    logic [31:0] rd_v [2];
    assign acc     = {r1_accepted, r0_accepted};
    assign done    = {r1_done, r0_done};
    assign rd_v[0] = r0_rdata;
    assign rd_v[1] = r1_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
        .clk(clk), .rstn(rstn),
        .r0_order(ord[0]), .r0_write(wr[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
        .r0_accepted(r0_accepted), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_order(ord[1]), .r1_write(wr[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
        .r1_accepted(r1_accepted), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .a_mem(a_mem), .sd_mem(sd_mem), .ld_mem(ld_mem),
        .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
        .busy(busy), .grant(grant)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // BRAM with RL-cycle read latency; returns junk when not reading so wrong sample cycles show up.
    logic [31:0] bram [256] = '{default: 32'h0};
    logic [31:0] pipe [RL];
    always @(posedge clk) begin
        if (mem_write_flag != 4'h0) bram[a_mem[7:0]] <= merge(bram[a_mem[7:0]], mem_write_flag, sd_mem);
        pipe[0] <= mem_read_flag ? bram[a_mem[7:0]] : $urandom;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign ld_mem = pipe[RL-1];

    typedef struct packed { logic wr; logic [31:0] data; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    task automatic request(input int p, input bit w, input logic [3:0] be, input logic [ADDR_W-1:0] ad,
                           input logic [31:0] d, output int acc_cyc);
        int   n;
        exp_t e;
        n = 0;
        acc_cyc = -1;
        @(posedge clk); #1;
        ord[p] = 1'b1; wr[p] = w; we[p] = be; addr[p] = ad; wdata[p] = d;
        while (n < 300) begin
            @(negedge clk);
            if (acc[p]) break;
            n++;
        end
        if (acc[p]) begin
            acc_cyc = cyc;
            e.wr = w;
            if (w) begin
                ref_mem[ad[7:0]] = merge(ref_mem[ad[7:0]], be, d);
                e.data = 32'h0;
            end else begin
                e.data = ref_mem[ad[7:0]];
            end
            if (p == 0) q0.push_back(e); else q1.push_back(e);
        end else begin
            n_checks++; n_fail++;
            $display("FAIL request_timeout: port %0d never accepted", p);
        end
        @(posedge clk); #1;
        ord[p] = 1'b0;
    endtask

    // Transaction-level model: one transaction at a time, done cycle counts as idle.
    bit          in_flight = 0, prev_idle = 1, model_grant = 1, fl_port = 0, fl_wr = 0, win = 0;
    int          due = 0;
    logic [ADDR_W-1:0] fl_addr;
    logic [1:0]  prev_ord = 2'b00, exp_acc, exp_done;
    logic        pw [2];
    logic [3:0]  pwe [2];
    logic [ADDR_W-1:0] pad [2];
    logic [31:0] pwd [2];
    logic [31:0] hold [2] = '{32'h0, 32'h0};
    exp_t        e_m;
    bit          pp;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_accepted", acc, 0);
                chk("rst_done", done, 0);
                chk("rst_strobes", {mem_write_flag, mem_read_flag, busy}, 0);
                chk("rst_a_sd", {a_mem, sd_mem}, 0);
                chk("rst_rdata", {r1_rdata, r0_rdata}, 0);
                chk("rst_grant", grant, 1);
                in_flight = 0; prev_idle = 1; model_grant = 1; prev_ord = 2'b00;
                hold[0] = 0; hold[1] = 0;
                q0.delete(); q1.delete();
            end else begin
                exp_acc = 2'b00;
                if (prev_idle && prev_ord != 2'b00) begin
                    if (prev_ord == 2'b11) win = RR ? !model_grant : 1'b0;
                    else win = prev_ord[1];
                    exp_acc = win ? 2'b10 : 2'b01;
                end
                chk("accepted", acc, exp_acc);
                exp_done = (in_flight && cyc == due) ? (fl_port ? 2'b10 : 2'b01) : 2'b00;
                chk("done", done, exp_done);
                if (done != 2'b00) begin
                    pp = done[1];
                    if ((pp ? q1.size() : q0.size()) == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL sb_underflow: done on port %0d with nothing outstanding", pp);
                    end else begin
                        if (pp) e_m = q1.pop_front(); else e_m = q0.pop_front();
                        if (!e_m.wr) begin
                            chk("load_rdata", rd_v[pp], e_m.data);
                            hold[pp] = e_m.data;
                        end
                    end
                end
                if (in_flight && cyc == due) in_flight = 0;
                if (exp_acc != 2'b00) begin
                    in_flight = 1; fl_port = win; fl_wr = pw[win]; fl_addr = pad[win];
                    due = cyc + (pw[win] ? 1 : 1 + RL);
                    model_grant = win;
                    chk("issue_wflag", mem_write_flag, pw[win] ? pwe[win] : 4'h0);
                    chk("issue_rflag", mem_read_flag, !pw[win]);
                    chk("issue_addr", a_mem, pad[win]);
                    if (pw[win]) chk("issue_sd", sd_mem, pwd[win]);
                end else begin
                    chk("idle_strobes", {mem_write_flag, mem_read_flag}, 0);
                    if (in_flight) chk("wait_addr_sd", {a_mem, sd_mem}, {fl_addr, 32'h0});
                end
                chk("busy", busy, in_flight);
                chk("grant", grant, model_grant);
                chk("rdata_hold", {r1_rdata, r0_rdata}, {hold[1], hold[0]});
                prev_idle = !in_flight;
                prev_ord  = {ord[1], ord[0]};
                for (int i = 0; i < 2; i++) begin
                    pw[i] = wr[i]; pwe[i] = we[i]; pad[i] = addr[i]; pwd[i] = wdata[i];
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
    endtask

    int a0, a1, ax;
    int a0s [10];

    initial begin
        for (int i = 0; i < 2; i++) begin
            ord[i] = 0; wr[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        request(0, 1'b1, 4'hF, 17'h00010, 32'hDEADBEEF, a0);
        repeat (3) @(negedge clk);
        request(0, 1'b0, 4'h0, 17'h00010, 32'h0, a0);
        repeat (RL + 3) @(negedge clk);
        chk("dir_load_value", r0_rdata, 32'hDEADBEEF);
        chk("dir_r1_untouched", r1_rdata, 32'h0);

        request(1, 1'b1, 4'h0, 17'h00010, 32'h12345678, a1);
        repeat (3) @(negedge clk);
        request(1, 1'b1, 4'h5, 17'h1FFFF, 32'hA5A5A5A5, a1);
        request(1, 1'b0, 4'h0, 17'h00010, 32'h0, a1);
        request(1, 1'b0, 4'h0, 17'h1FFFF, 32'h0, a1);
        repeat (RL + 3) @(negedge clk);
        chk("dir_we0_noop", r1_rdata, 32'h00A500A5);

        do_reset();
        fork
            for (int i = 0; i < 10; i++) request(0, 1'b0, 4'h0, ADDR_W'(i), 32'h0, a0s[i]);
            request(1, 1'b0, 4'h0, 17'h00010, 32'h0, a1);
        join
        if (RR) begin
            chk("rr_p0_first", a0s[0] < a1, 1);
            chk("rr_p1_before_p0_again", a1 < a0s[1], 1);
        end else begin
            chk("fixed_p0_first", a0s[0] < a1, 1);
            chk("fixed_p1_starved", a1 > a0s[9], 1);
        end
        repeat (RL + 3) @(negedge clk);

        request(0, 1'b0, 4'h0, 17'h00010, 32'h0, a0);
        @(negedge clk); #2 rstn = 1'b0;
        #1;
        chk("async_rst_outputs", {acc, done, mem_write_flag, mem_read_flag, busy, a_mem, sd_mem}, 0);
        chk("async_rst_rdata", {r1_rdata, r0_rdata}, 0);
        chk("async_rst_grant", grant, 1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (8) @(negedge clk);
        request(0, 1'b0, 4'h0, 17'h00010, 32'h0, ax);
        chk("post_rst_accepted", ax >= 0, 1);
        repeat (RL + 3) @(negedge clk);
        chk("post_rst_load", r0_rdata, 32'hDEADBEEF);

        fork
            begin
                int ac;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    request(0, 1'($urandom_range(0, 1)), 4'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom, ac);
                end
            end
            begin
                int ac;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    request(1, 1'($urandom_range(0, 1)), 4'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom, ac);
                end
            end
        join
        repeat (RL + 6) @(negedge clk);
        chk("sb_empty_p0", q0.size(), 0);
        chk("sb_empty_p1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
